seq_detect_param: RTL

Parametrised serial pattern detector for single-bit input streams. It generalises the team's fixed-sequence detector to any pattern width and value, with an input enable, selectable overlapping or non-overlapping matching, and an optional saturating match counter. It sits on a serial data line in the same clock domain as its producer and drives a one-cycle match pulse to downstream control logic.

---
 rtl/seq_detect_param.sv | 115 +++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
`timescale 1ns/1ps
// seq_detect_param
// Parametrised serial pattern detector for a single-bit input stream.
// Each enabled edge shifts bit `a` into a PAT_W-deep history. When the
// history holds PAT_W valid bits equal to PATTERN, a one-cycle registered
// pulse is raised on `y`. The MSB of PATTERN is the oldest bit received.
//
// Parameters:
//   PAT_W    pattern length in bits, 2..32
//   PATTERN  pattern value, PAT_W bits wide
//   CNT_W    match counter width, 1..32
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         sample enable; `a` is consumed only when en=1
//   a          serial data bit
//   overlap    1 = overlapping matches, 0 = history flushed after a match
//   clr_cnt    synchronous clear of match_cnt
//   y          registered one-cycle match pulse
//   match_cnt  saturating match count
//
// Build option:
//   SEQ_DETECT_CNT_EN  when defined, the saturating match counter and
//                      clr_cnt are implemented; otherwise match_cnt is
//                      tied to zero and clr_cnt is ignored.

module seq_detect_param #(
    parameter int unsigned          PAT_W   = 4,
    parameter logic [PAT_W-1:0]     PATTERN = PAT_W'(4'b1101),
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Elaboration-time parameter range checks
    if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W=%0d out of range 2..32", PAT_W);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W=%0d out of range 1..32", CNT_W);
    end

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_nxt_c;
    logic [FILL_W-1:0] nfill_c;
    logic [FILL_W-1:0] fill_d_c;
    logic              hit_c;

    // Next history, saturating fill count and match decision
    always_comb begin
        hist_nxt_c = hist;
        nfill_c    = fill;
        fill_d_c   = fill;
        hit_c      = 1'b0;

        if (en) begin
            hist_nxt_c = {hist[PAT_W-2:0], a};
            nfill_c    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
            hit_c      = (nfill_c == FILL_FULL) && (hist_nxt_c == PATTERN);
            // Non-overlapping mode requires PAT_W fresh bits after a match
            fill_d_c   = (hit_c && !overlap) ? '0 : nfill_c;
        end
    end

    // History, fill and match pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            y    <= 1'b0;
        end else begin
            hist <= hist_nxt_c;
            fill <= fill_d_c;
            y    <= hit_c;
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Saturating match counter; a clear coinciding with a hit leaves 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= hit_c ? CNT_W'(1) : '0;
        end else if (hit_c && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_cnt = cnt;
`else
    logic cnt_unused;

    assign cnt_unused = clr_cnt;
    assign match_cnt  = '0;
`endif

endmodule
